// File: rtl/spi_pkg.sv
// Shared types for the SPI host transfer engine.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      NEXT,
      HOLD
   } spi_host_state_e;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCK timing: half-period divider plus leading/trailing edge strobes.
module spi_clk_gen #(
   parameter int ClkDivWidth = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   en,
   input  logic                   shift_en,
   input  logic [ClkDivWidth-1:0] div,
   output logic                   tick,
   output logic                   lead,
   output logic                   trail
);

   logic [ClkDivWidth-1:0] cnt_reg;
   logic                   phase_reg;

   // Count 0..div while enabled; phase alternates lead/trail on every SHIFT tick.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_reg   <= '0;
         phase_reg <= 1'b0;
      end else begin
         if (!en || cnt_reg == div) begin
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (!shift_en) begin
            phase_reg <= 1'b0;
         end else if (tick) begin
            phase_reg <= ~phase_reg;
         end
      end
   end

   assign tick  = en && (cnt_reg == div);
   assign lead  = tick && shift_en && !phase_reg;
   assign trail = tick && shift_en && phase_reg;

endmodule

// File: rtl/spi_host_xfer.sv
// SPI master: runtime mode/divider/bit order, multi-word bursts with CS held low.
module spi_host_xfer
   import spi_pkg::*;
#(
   parameter int DataWidth   = 8,
   parameter int NumCs       = 1,
   parameter int ClkDivWidth = 8
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic                                    cfg_cpol_i,
   input  logic                                    cfg_cpha_i,
   input  logic                                    cfg_lsb_first_i,
   input  logic [ClkDivWidth-1:0]                  cfg_clk_div_i,
   input  logic [(NumCs > 1 ? $clog2(NumCs) : 1)-1:0] cfg_cs_sel_i,
   input  logic                                    tx_valid_i,
   output logic                                    tx_ready_o,
   input  logic [DataWidth-1:0]                    tx_data_i,
   input  logic                                    tx_last_i,
   output logic                                    rx_valid_o,
   output logic [DataWidth-1:0]                    rx_data_o,
   output logic                                    busy_o,
   output logic                                    sck_o,
   output logic                                    sdo_o,
   input  logic                                    sdi_i,
   output logic [NumCs-1:0]                        csn_o
);

   localparam int CsW  = (NumCs > 1) ? $clog2(NumCs) : 1;
   localparam int BitW = $clog2(2 * DataWidth);

   spi_host_state_e      state;
   spi_mode_t            mode_q;
   logic                 lsb_q;
   logic [ClkDivWidth-1:0] div_q;
   logic [CsW-1:0]       cs_sel_q;
   logic                 last_q;
   logic [DataWidth-1:0] tx_sr;
   logic [DataWidth-1:0] rx_sr;
   logic [BitW-1:0]      bit_cnt;
   logic                 sck_reg, sdo_reg, ready_reg, busy_reg, rx_valid_reg;
   logic [NumCs-1:0]     csn_reg;
   logic [DataWidth-1:0] rx_data_reg;

   logic                 tick, lead, trail, clk_en, accept;
   logic                 lsb_sel, first_bit, tx_cur, tx_nxt, sample_now, last_edge;
   logic [DataWidth-1:0] tx_shifted, rx_shifted, rx_next;
   logic [NumCs-1:0]     cs_hit_in, cs_hit_q;

   // Chip-select decode: out-of-range index selects nothing.
   for (genvar gi = 0; gi < NumCs; gi++) begin : g_cs_dec
      assign cs_hit_in[gi] = (cfg_cs_sel_i == CsW'(gi));
      assign cs_hit_q[gi]  = (cs_sel_q == CsW'(gi));
   end

   assign clk_en = (state == SETUP) || (state == SHIFT) || (state == HOLD);
   assign accept = tx_valid_i && ready_reg;

   spi_clk_gen #(
      .ClkDivWidth(ClkDivWidth)
   ) u_clk_gen (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en      (clk_en),
      .shift_en(state == SHIFT),
      .div     (div_q),
      .tick    (tick),
      .lead    (lead),
      .trail   (trail)
   );

   // In IDLE the config is loading this very cycle, so take bit order from the input.
   assign lsb_sel    = (state == IDLE) ? cfg_lsb_first_i : lsb_q;
   assign first_bit  = lsb_sel ? tx_data_i[0] : tx_data_i[DataWidth-1];
   assign tx_cur     = lsb_q ? tx_sr[0] : tx_sr[DataWidth-1];
   assign tx_nxt     = lsb_q ? tx_sr[1] : tx_sr[DataWidth-2];
   assign tx_shifted = lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
   assign rx_shifted = lsb_q ? {sdi_i, rx_sr[DataWidth-1:1]} : {rx_sr[DataWidth-2:0], sdi_i};
   assign sample_now = mode_q.cpha ? trail : lead;
   assign rx_next    = sample_now ? rx_shifted : rx_sr;
   assign last_edge  = (bit_cnt == BitW'(2 * DataWidth - 1));

   // Transfer FSM with all pad and handshake outputs registered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         mode_q       <= '0;
         lsb_q        <= 1'b0;
         div_q        <= '0;
         cs_sel_q     <= '0;
         last_q       <= 1'b0;
         tx_sr        <= '0;
         rx_sr        <= '0;
         bit_cnt      <= '0;
         sck_reg      <= 1'b0;
         sdo_reg      <= 1'b0;
         csn_reg      <= '1;
         ready_reg    <= 1'b0;
         busy_reg     <= 1'b0;
         rx_valid_reg <= 1'b0;
         rx_data_reg  <= '0;
      end else begin
         rx_valid_reg <= 1'b0;
         case (state)
            IDLE: begin
               mode_q.cpol <= cfg_cpol_i;
               mode_q.cpha <= cfg_cpha_i;
               lsb_q       <= cfg_lsb_first_i;
               div_q       <= cfg_clk_div_i;
               cs_sel_q    <= cfg_cs_sel_i;
               sck_reg     <= cfg_cpol_i;
               ready_reg   <= 1'b1;
               if (accept) begin
                  tx_sr     <= tx_data_i;
                  last_q    <= tx_last_i;
                  sdo_reg   <= first_bit;
                  csn_reg   <= ~cs_hit_in;
                  ready_reg <= 1'b0;
                  busy_reg  <= 1'b1;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               bit_cnt <= '0;
               sck_reg <= mode_q.cpol;
               csn_reg <= ~cs_hit_q;
               if (tick) begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (tick) begin
                  sck_reg <= ~sck_reg;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (sample_now) begin
                     rx_sr <= rx_shifted;
                  end
                  if (mode_q.cpha) begin
                     if (lead) begin
                        sdo_reg <= tx_cur;
                     end else begin
                        tx_sr <= tx_shifted;
                     end
                  end else if (trail && !last_edge) begin
                     sdo_reg <= tx_nxt;
                     tx_sr   <= tx_shifted;
                  end
                  if (last_edge) begin
                     bit_cnt      <= '0;
                     rx_data_reg  <= rx_next;
                     rx_valid_reg <= 1'b1;
                     if (last_q) begin
                        state <= HOLD;
                     end else begin
                        state     <= NEXT;
                        ready_reg <= 1'b1;
                     end
                  end
               end
            end
            NEXT: begin
               sck_reg <= mode_q.cpol;
               if (accept) begin
                  tx_sr     <= tx_data_i;
                  last_q    <= tx_last_i;
                  sdo_reg   <= first_bit;
                  ready_reg <= 1'b0;
                  state     <= SETUP;
               end
            end
            HOLD: begin
               sck_reg <= mode_q.cpol;
               if (tick) begin
                  csn_reg   <= '1;
                  busy_reg  <= 1'b0;
                  ready_reg <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign tx_ready_o = ready_reg;
   assign rx_valid_o = rx_valid_reg;
   assign rx_data_o  = rx_data_reg;
   assign busy_o     = busy_reg;
   assign sck_o      = sck_reg;
   assign sdo_o      = sdo_reg;
   assign csn_o      = csn_reg;

endmodule
